// File: rtl/mem_ctrl_if.sv
// Pipeline/RAM-facing bus of the byte-serial memory controller.
// The controller uses the slave modport; the environment (stages, RAM, stall controller) uses master.
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;

  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;

  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  logic        stallreq_if;
  logic        stallreq_mem;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_a, ram_wr,
           stallreq_if, stallreq_mem
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_a, ram_wr,
           stallreq_if, stallreq_mem
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IF fetches and MEM loads/stores onto the 8-bit RAM bus.
// Optional feature: define IO_FULL_WAIT_EN to hold IO-window stores while the UART buffer is full.
module mem_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       io_buffer_full,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;

  logic [2:0]  len_ext;
  logic [7:0]  wbyte;
  logic        io_wait;
  logic        if_done_c, mem_done_c;
  logic [31:0] ram_a_c;
  logic [7:0]  ram_dout_c;
  logic        ram_wr_c;

  assign len_ext = {1'b0, len_q};

`ifdef IO_FULL_WAIT_EN
  assign io_wait = bus.mem_req & bus.mem_we & (bus.mem_addr[17:16] == 2'b11) & io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_wait = 1'b0;
`endif

  always_comb begin
    wbyte = 8'h00;
    case (cnt_q[1:0])
      2'd0: wbyte = wdata_q[7:0];
      2'd1: wbyte = wdata_q[15:8];
      2'd2: wbyte = wdata_q[23:16];
      2'd3: wbyte = wdata_q[31:24];
      default: wbyte = 8'h00;
    endcase
  end

  // NOTE: every variable written here gets its default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_req && !io_wait) begin
          owner_d = OWN_MEM;
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          len_d   = (bus.mem_len == 2'd2) ? 2'd3 : bus.mem_len;
          cnt_d   = 3'd0;
          data_d  = 32'h0;
          state_d = bus.mem_we ? WRITE : READ;
        end else if (bus.if_req && !bus.mem_req) begin
          owner_d = OWN_IF;
          addr_d  = bus.if_addr;
          len_d   = 2'd3;
          cnt_d   = 3'd0;
          data_d  = 32'h0;
          state_d = READ;
        end
      end
      READ: begin
        // ram_din carries the byte addressed in the previous cycle, i.e. byte cnt-1.
        case (cnt_q)
          3'd1: data_d[7:0]   = bus.ram_din;
          3'd2: data_d[15:8]  = bus.ram_din;
          3'd3: data_d[23:16] = bus.ram_din;
          3'd4: data_d[31:24] = bus.ram_din;
          default: ;
        endcase
        if (cnt_q == len_ext + 3'd1) state_d = DONE;
        else                         cnt_d   = cnt_q + 3'd1;
      end
      WRITE: begin
        if (cnt_q == len_ext) state_d = DONE;
        else                  cnt_d   = cnt_q + 3'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // While frozen, keep re-addressing the byte in flight so ram_din holds it when rdy returns.
  always_comb begin
    ram_a_c    = 32'h0;
    ram_dout_c = 8'h00;
    ram_wr_c   = 1'b0;
    case (state_q)
      READ: begin
        if (!rdy && cnt_q != 3'd0)  ram_a_c = addr_q + {29'd0, cnt_q - 3'd1};
        else if (cnt_q <= len_ext)  ram_a_c = addr_q + {29'd0, cnt_q};
      end
      WRITE: begin
        ram_a_c    = addr_q + {29'd0, cnt_q};
        ram_dout_c = wbyte;
        ram_wr_c   = rdy;
      end
      default: ;
    endcase
  end

  assign if_done_c  = rdy & (state_q == DONE) & (owner_q == OWN_IF);
  assign mem_done_c = rdy & (state_q == DONE) & (owner_q == OWN_MEM);

  assign bus.if_done      = if_done_c;
  assign bus.mem_done     = mem_done_c;
  assign bus.if_inst      = data_q;
  assign bus.mem_rdata    = data_q;
  assign bus.ram_a        = ram_a_c;
  assign bus.ram_dout     = ram_dout_c;
  assign bus.ram_wr       = ram_wr_c;
  assign bus.stallreq_if  = bus.if_req & ~if_done_c;
  assign bus.stallreq_mem = bus.mem_req & ~mem_done_c;

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, since data_q drives if_inst/mem_rdata directly.
      state_q <= IDLE;
      owner_q <= OWN_IF;
      cnt_q   <= 3'd0;
      len_q   <= 2'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
    end else if (rdy) begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized fetch/load/store traffic
// checked against a byte-array reference memory and spec-level latency rules.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic io_full = 1'b0;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .io_buffer_full (io_full),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // RAM contents as seen on the bus, and the reference model of what they should be.
  logic [7:0] ram     [bit [31:0]];
  logic [7:0] exp_mem [bit [31:0]];

  int n_vec  = 0;
  int n_fail = 0;

  always @(posedge clk)
    bus.ram_din <= ram.exists(bus.ram_a) ? ram[bus.ram_a] : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fall();
    @(negedge clk);
  endtask

  // Let inputs settle, then record any write the RAM will take at the coming edge.
  task automatic settle();
    #1;
    if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
  endtask

  task automatic prep(input logic [31:0] addr, input int n);
    logic [31:0] a;
    logic [7:0]  b;
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      if (!exp_mem.exists(a)) begin
        b = 8'($urandom);
        exp_mem[a] = b;
        ram[a]     = b;
      end
    end
  endtask

  task automatic run_txn(input string tag, input bit fetch, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall_at, input int stall_len);
    int n, lat, got, wr_cnt, wr_in_stall, stall_bad;
    logic [31:0] exp_data;
    logic done;
    bit store;
    store = we && !fetch;
    n = fetch ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
    prep(addr, n);
    exp_data = 32'h0;
    if (!store)
      for (int i = 0; i < n; i++) exp_data |= {24'd0, exp_mem[addr + i]} << (8 * i);
    else
      for (int i = 0; i < n; i++) exp_mem[addr + i] = wdata[8*i +: 8];
    lat = fetch ? 6 : (store ? n + 1 : n + 2);
    got = 0; wr_cnt = 0; wr_in_stall = 0; stall_bad = 0;

    fall();
    if (fetch) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_len = len;
      bus.mem_addr = addr; bus.mem_wdata = wdata;
    end
    settle();

    for (int t = 1; t <= 40; t++) begin
      fall();
      if (stall_len > 0 && t == stall_at) rdy = 1'b0;
      if (stall_len > 0 && t == stall_at + stall_len) rdy = 1'b1;
      settle();
      if (!rdy && bus.ram_wr) wr_in_stall++;
      if (bus.ram_wr) wr_cnt++;
      done = fetch ? bus.if_done : bus.mem_done;
      if (done) begin
        got = t;
        break;
      end
      if (!(fetch ? bus.stallreq_if : bus.stallreq_mem)) stall_bad++;
    end

    if (stall_len == 0) check({tag, "/latency"}, 32'(got), 32'(lat));
    else                check({tag, "/done_seen"}, {31'd0, got > 0}, 32'd1);
    if (got > 0) begin
      check({tag, "/stall_before_done"}, 32'(stall_bad), 32'd0);
      check({tag, "/stall_at_done"}, {31'd0, fetch ? bus.stallreq_if : bus.stallreq_mem}, 32'd0);
      if (fetch)      check({tag, "/if_inst"}, bus.if_inst, exp_data);
      else if (!we)   check({tag, "/mem_rdata"}, bus.mem_rdata, exp_data);
      if (store) begin
        check({tag, "/wr_cycles"}, 32'(wr_cnt), 32'(n));
        if (stall_len > 0) check({tag, "/wr_in_stall"}, 32'(wr_in_stall), 32'd0);
        for (int i = 0; i < n; i++)
          check({tag, "/ram_byte"}, {24'd0, ram[addr + i]}, {24'd0, exp_mem[addr + i]});
      end
    end
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    rdy = 1'b1;
  endtask

  initial begin : stim
    int t_mem, t_if, bad_stall, early_if, wr_early, stall_low, kind;
    logic [31:0] base, addr;
    logic [7:0]  old_b2;

    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'd0;
    bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;

    // Reset state
    repeat (3) begin fall(); settle(); end
    check("rst/ram_wr",    {31'd0, bus.ram_wr},   32'd0);
    check("rst/ram_a",     bus.ram_a,             32'd0);
    check("rst/ram_dout",  {24'd0, bus.ram_dout}, 32'd0);
    check("rst/if_done",   {31'd0, bus.if_done},  32'd0);
    check("rst/mem_done",  {31'd0, bus.mem_done}, 32'd0);
    check("rst/if_inst",   bus.if_inst,           32'd0);
    check("rst/mem_rdata", bus.mem_rdata,         32'd0);
    rst = 1'b0;

    // Word fetch from 0x10
    ram[32'h10] = 8'h13; ram[32'h11] = 8'h05; ram[32'h12] = 8'h10; ram[32'h13] = 8'h00;
    exp_mem[32'h10] = 8'h13; exp_mem[32'h11] = 8'h05; exp_mem[32'h12] = 8'h10; exp_mem[32'h13] = 8'h00;
    run_txn("fetch10", 1'b1, 1'b0, 2'd3, 32'h10, 32'h0, 0, 0);
    check("fetch10/inst_const", bus.if_inst, 32'h0010_0513);

    // Word store 0xDEADBEEF to 0x100
    run_txn("store100", 1'b0, 1'b1, 2'd3, 32'h100, 32'hDEAD_BEEF, 0, 0);
    check("store100/b0", {24'd0, ram[32'h100]}, 32'hEF);
    check("store100/b3", {24'd0, ram[32'h103]}, 32'hDE);

    // Byte load 0x200 holding 0x80 (zero-extended)
    ram[32'h200] = 8'h80; exp_mem[32'h200] = 8'h80;
    run_txn("load200", 1'b0, 1'b0, 2'd0, 32'h200, 32'h0, 0, 0);
    check("load200/const", bus.mem_rdata, 32'h0000_0080);

    // Simultaneous requests: MEM first, fetch accepted after one idle gap
    prep(32'h300, 4);
    prep(32'h10, 4);
    fall();
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd3; bus.mem_addr = 32'h300;
    settle();
    t_mem = 0; bad_stall = 0; early_if = 0;
    for (int t = 1; t <= 30; t++) begin
      fall(); settle();
      if (bus.if_done) early_if++;
      if (bus.mem_done) begin t_mem = t; break; end
      if (!bus.stallreq_if || !bus.stallreq_mem) bad_stall++;
    end
    check("both/mem_latency", 32'(t_mem), 32'd6);
    check("both/mem_rdata", bus.mem_rdata,
          {exp_mem[32'h303], exp_mem[32'h302], exp_mem[32'h301], exp_mem[32'h300]});
    check("both/stalls_high", 32'(bad_stall), 32'd0);
    check("both/no_early_if", 32'(early_if), 32'd0);
    bus.mem_req = 1'b0;
    t_if = 0;
    for (int t = 1; t <= 30; t++) begin
      fall(); settle();
      if (bus.if_done) begin t_if = t; break; end
    end
    check("both/if_after_mem", 32'(t_if), 32'd7);
    check("both/if_inst", bus.if_inst, 32'h0010_0513);
    bus.if_req = 1'b0;

    // rdy low for 3 cycles mid word fetch, and mid word store
    run_txn("rdy_fetch", 1'b1, 1'b0, 2'd3, 32'h0000_0040, 32'h0, 2, 3);
    run_txn("rdy_store", 1'b0, 1'b1, 2'd3, 32'h0000_0500, 32'h1234_5678, 2, 2);

    // Reset during a word store: two bytes land, no done, ram_wr drops
    prep(32'h400, 4);
    old_b2 = exp_mem[32'h402];
    fall();
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd3;
    bus.mem_addr = 32'h400; bus.mem_wdata = 32'hCAFE_F00D;
    settle();
    fall(); settle();
    fall(); rst = 1'b1; bus.mem_req = 1'b0; settle();
    fall(); settle();
    check("rst_mid/ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    check("rst_mid/ram_a",  bus.ram_a,           32'd0);
    rst = 1'b0;
    t_mem = 0;
    for (int t = 1; t <= 4; t++) begin
      fall(); settle();
      if (bus.mem_done || bus.ram_wr) t_mem++;
    end
    check("rst_mid/no_done", 32'(t_mem), 32'd0);
    exp_mem[32'h400] = 8'h0D; exp_mem[32'h401] = 8'hF0;
    check("rst_mid/b1", {24'd0, ram[32'h401]}, {24'd0, exp_mem[32'h401]});
    check("rst_mid/b2", {24'd0, ram[32'h402]}, {24'd0, old_b2});

    // IO-window byte store while the UART buffer is full
`ifdef IO_FULL_WAIT_EN
    prep(32'h3_0000, 1);
    exp_mem[32'h3_0000] = 8'hA5;
    fall();
    io_full = 1'b1;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd0;
    bus.mem_addr = 32'h3_0000; bus.mem_wdata = 32'h0000_00A5;
    settle();
    wr_early = 0; stall_low = 0;
    for (int t = 1; t <= 4; t++) begin
      fall(); settle();
      if (bus.ram_wr || bus.mem_done) wr_early++;
      if (!bus.stallreq_mem) stall_low++;
    end
    fall(); io_full = 1'b0; settle();
    if (bus.ram_wr) wr_early++;
    check("io/no_wr_while_full", 32'(wr_early), 32'd0);
    check("io/stall_held", 32'(stall_low), 32'd0);
    fall(); settle();
    check("io/wr_after_drop", {31'd0, bus.ram_wr}, 32'd1);
    fall(); settle();
    check("io/done", {31'd0, bus.mem_done}, 32'd1);
    bus.mem_req = 1'b0;
    check("io/byte", {24'd0, ram[32'h3_0000]}, 32'hA5);
`else
    io_full = 1'b1;
    run_txn("io_ignored", 1'b0, 1'b1, 2'd0, 32'h3_0000, 32'h0000_00A5, 0, 0);
    io_full = 1'b0;
`endif

    // Randomized traffic, including half-word/illegal-length accesses and 32-bit wrap
    for (int k = 0; k < 50; k++) begin
      case ($urandom_range(0, 3))
        0:       base = 32'h0000_1000;
        1:       base = 32'hFFFF_FFFC;
        2:       base = 32'h0001_2340;
        default: base = $urandom;
      endcase
      addr = base + 32'($urandom_range(0, 7));
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0)
        run_txn("rnd_stall", kind == 0, kind == 2, 2'($urandom_range(0, 3)), addr, $urandom,
                $urandom_range(1, 3), $urandom_range(1, 3));
      else
        run_txn("rnd", kind == 0, kind == 2, 2'($urandom_range(0, 3)), addr, $urandom, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
